// File: rtl/sid_pkg.sv
// rtl/sid_pkg.sv - shared types and constants for the SID pot ADC
package sid_pkg;

  // Conversion phase: discharge the pot capacitor, then time its recharge
  typedef enum logic {POT_DISCHARGE, POT_MEASURE} sid_pot_state_t;

  localparam int POT_CNT_BITS = 8;

  typedef logic [POT_CNT_BITS-1:0] sid_pot_t;

endpackage : sid_pkg

// File: rtl/sid_sync.sv
// rtl/sid_sync.sv - generic N-stage, W-bit synchronizer for asynchronous inputs
module sid_sync #(
  parameter int N = 2,
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [N-1:0][W-1:0] sync_q;
  logic [N-1:0][W-1:0] sync_d;

  // Shift the raw input down the chain; stage 0 takes the async input
  always_comb begin
    sync_d    = sync_q;
    sync_d[0] = d;
    for (int i = 1; i < N; i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  // Synchronizer flops, clocked every clk
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[N-1];

endmodule : sid_sync

// File: rtl/sid_pot_adc.sv
// rtl/sid_pot_adc.sv - POTX/POTY RC charge-time ADC using phi2 cycle counting
module sid_pot_adc
  import sid_pkg::*;
#(
  parameter int CHANNELS = 2,
  parameter int CNT_BITS = POT_CNT_BITS,
  parameter int SYNC_FF  = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         phi2_en,
  input  logic [CHANNELS-1:0]          pot_cmp,
  output logic                         pot_discharge,
  output logic [CHANNELS*CNT_BITS-1:0] pot_val,
  output logic                         pot_valid
);

  localparam logic [CNT_BITS-1:0] CNT_MAX = '1;

  logic [CHANNELS-1:0] cmp_sync;

  sid_pot_state_t state_q, state_d;
  logic [CNT_BITS-1:0] cnt_q, cnt_d;
  logic [CHANNELS-1:0] done_q, done_d;
  logic [CHANNELS-1:0][CNT_BITS-1:0] shadow_q, shadow_d;
  logic [CHANNELS-1:0][CNT_BITS-1:0] val_q, val_d;
  logic valid_q, valid_d;

  // Comparator outputs are asynchronous to clk; the FSM only sees the synced copy
  sid_sync #(
    .N (SYNC_FF),
    .W (CHANNELS)
  ) u_cmp_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (pot_cmp),
    .q     (cmp_sync)
  );

  // Phase sequencing, per-channel capture and atomic result publication
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    done_d   = done_q;
    shadow_d = shadow_q;
    val_d    = val_q;
    valid_d  = 1'b0;
    if (phi2_en) begin
      cnt_d = cnt_q + 1'b1;
      unique case (state_q)
        POT_DISCHARGE: begin
          if (cnt_q == CNT_MAX) begin
            state_d = POT_MEASURE;
            done_d  = '0;
          end
        end
        POT_MEASURE: begin
          // First threshold crossing wins; later comparator activity is ignored
          for (int c = 0; c < CHANNELS; c++) begin
            if (!done_q[c] && cmp_sync[c]) begin
              shadow_d[c] = cnt_q;
              done_d[c]   = 1'b1;
            end
          end
          // A channel not yet captured reads as full scale; a crossing on this
          // very strobe would also have captured CNT_MAX, so both cases agree
          if (cnt_q == CNT_MAX) begin
            for (int c = 0; c < CHANNELS; c++) begin
              val_d[c] = done_q[c] ? shadow_q[c] : CNT_MAX;
            end
            valid_d = 1'b1;
            state_d = POT_DISCHARGE;
          end
        end
        default: state_d = POT_DISCHARGE;
      endcase
    end
  end

  // State, counter and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= POT_DISCHARGE;
      cnt_q    <= '0;
      done_q   <= '0;
      shadow_q <= '0;
      val_q    <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      done_q   <= done_d;
      shadow_q <= shadow_d;
      val_q    <= val_d;
      valid_q  <= valid_d;
    end
  end

  assign pot_discharge = (state_q == POT_DISCHARGE);
  assign pot_val       = val_q;
  assign pot_valid     = valid_q;

endmodule : sid_pot_adc

// File: tb/tb_sid_pot_adc.sv
// tb/tb_sid_pot_adc.sv - randomized self-checking bench for sid_pot_adc
module tb_sid_pot_adc;
  import sid_pkg::*;

  localparam int CH   = 2;
  localparam int CB   = POT_CNT_BITS;
  localparam int HALF = 1 << CB;
  localparam int FULL = 2 * HALF;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           phi2_en;
  logic [CH-1:0]  pot_cmp;
  logic           pot_discharge;
  logic [CH*CB-1:0] pot_val;
  logic           pot_valid;

  int n_cmp = 0;
  int n_err = 0;

  // Comparator level presented at each strobe of the two phases
  logic [CH-1:0] dis_w  [HALF];
  logic [CH-1:0] meas_w [HALF];
  logic [CH*CB-1:0] held_val;

  always #5 clk = ~clk;

  sid_pot_adc #(
    .CHANNELS (CH),
    .CNT_BITS (CB),
    .SYNC_FF  (2)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .phi2_en       (phi2_en),
    .pot_cmp       (pot_cmp),
    .pot_discharge (pot_discharge),
    .pot_val       (pot_val),
    .pot_valid     (pot_valid)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reading = index of first measure strobe with comparator high, else full scale
  function automatic logic [CH*CB-1:0] model_result();
    logic [CH*CB-1:0] r;
    sid_pot_t v;
    for (int c = 0; c < CH; c++) begin
      v = sid_pot_t'(HALF - 1);
      for (int k = HALF - 1; k >= 0; k--) begin
        if (meas_w[k][c]) v = sid_pot_t'(k);
      end
      r[c*CB +: CB] = v;
    end
    return r;
  endfunction

  task automatic clear_waves();
    for (int k = 0; k < HALF; k++) begin
      dis_w[k]  = '0;
      meas_w[k] = '0;
    end
  endtask

  // Random discharge noise, random first crossing (or none), random chatter afterwards
  task automatic random_waves();
    int first [CH];
    for (int c = 0; c < CH; c++) first[c] = int'($urandom_range(0, HALF + 40));
    for (int k = 0; k < HALF; k++) begin
      dis_w[k] = CH'($urandom);
      for (int c = 0; c < CH; c++) begin
        if (k < first[c])       meas_w[k][c] = 1'b0;
        else if (k == first[c]) meas_w[k][c] = 1'b1;
        else                    meas_w[k][c] = 1'($urandom);
      end
    end
  endtask

  // One phi2 strobe, comparator settled three clocks ahead; returns at the next negedge
  task automatic strobe(input logic [CH-1:0] cmp);
    pot_cmp = cmp;
    repeat (3) @(negedge clk);
    phi2_en = 1'b1;
    @(negedge clk);
    phi2_en = 1'b0;
  endtask

  task automatic convert(input int stop_at, input int freeze_at);
    logic [CH*CB-1:0] exp_val;
    logic [CH-1:0] cmp;
    exp_val = model_result();
    for (int s = 1; s <= stop_at; s++) begin
      cmp = (s <= HALF) ? dis_w[s-1] : meas_w[s-HALF-1];
      strobe(cmp);
      check("discharge", 32'(pot_discharge), 32'((s < HALF) || (s == FULL)));
      check("valid", 32'(pot_valid), 32'(s == FULL));
      if (s == FULL) begin
        check("result", 32'(pot_val), 32'(exp_val));
        held_val = exp_val;
      end else begin
        check("held", 32'(pot_val), 32'(held_val));
      end
      if (s == freeze_at) begin
        for (int i = 0; i < 1000; i++) begin
          pot_cmp = CH'($urandom);
          @(negedge clk);
          check("frz_valid", 32'(pot_valid), 32'd0);
          check("frz_dis", 32'(pot_discharge), 32'(s < HALF));
        end
      end
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    phi2_en  = 1'b0;
    pot_cmp  = '0;
    held_val = '0;
    repeat (3) @(negedge clk);
    check("rst_dis", 32'(pot_discharge), 32'd1);
    check("rst_val", 32'(pot_val), 32'd0);
    check("rst_valid", 32'(pot_valid), 32'd0);
    rst_n = 1'b1;

    // Comparators never trip: full scale on both channels
    clear_waves();
    convert(FULL, 0);

    // ch1 above threshold from the start, ch0 crosses at 100
    clear_waves();
    dis_w[HALF-1] = 2'b10;
    for (int k = 0; k < HALF; k++) meas_w[k] = {1'b1, (k >= 100) ? 1'b1 : 1'b0};
    convert(FULL, 0);

    // Single-strobe pulse on ch0 is still captured
    clear_waves();
    meas_w[37][0] = 1'b1;
    convert(FULL, 0);

    // Activity only during discharge is ignored
    clear_waves();
    for (int k = 10; k < HALF - 5; k++) dis_w[k] = '1;
    convert(FULL, 0);
    clear_waves();
    for (int k = 200; k < HALF; k++) meas_w[k] = '1;
    convert(FULL, 0);

    // Randomized conversions
    for (int n = 0; n < 5; n++) begin
      random_waves();
      convert(FULL, 0);
    end

    // Prior result, then reset in the middle of the measure phase
    clear_waves();
    meas_w[55][0] = 1'b1;
    meas_w[55][1] = 1'b1;
    convert(FULL, 0);
    random_waves();
    convert(HALF + 129, 0);
    rst_n = 1'b0;
    #1;
    check("mid_rst_val", 32'(pot_val), 32'd0);
    check("mid_rst_dis", 32'(pot_discharge), 32'd1);
    check("mid_rst_valid", 32'(pot_valid), 32'd0);
    held_val = '0;
    @(negedge clk);
    rst_n = 1'b1;
    random_waves();
    convert(FULL, 0);

    // phi2_en held low for 1000 clocks in the middle of measure
    random_waves();
    convert(FULL, HALF + 44);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule : tb_sid_pot_adc
